// File: rtl/dlfloat16_fpu_sequencer.sv
// dlfloat16_fpu_sequencer
// Single-issue sequencer and round-robin 2-way arbiter in front of the
// DLFloat16 FPU cluster. Holds opcode/operands stable for the unit latency,
// captures result and flags, and returns them tagged to the requester.
// Optional macro DLF_SEQ_OPCHECK_EN: only opcodes 0001..0101 are issued;
// any other opcode is answered at once with data 0 and the invalid-op flag.
module dlfloat16_fpu_sequencer #(
    parameter int LAT_SGN   = 1,
    parameter int LAT_ARITH = 3,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [3:0]       i_req0_op,
    input  logic [1:0]       i_req0_sel,
    input  logic [15:0]      i_req0_a,
    input  logic [15:0]      i_req0_b,
    input  logic [TAG_W-1:0] i_req0_tag,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [3:0]       i_req1_op,
    input  logic [1:0]       i_req1_sel,
    input  logic [15:0]      i_req1_a,
    input  logic [15:0]      i_req1_b,
    input  logic [TAG_W-1:0] i_req1_tag,
    output logic [3:0]       o_fu_ena,
    output logic [1:0]       o_fu_sel,
    output logic [15:0]      o_fu_in1,
    output logic [15:0]      o_fu_in2,
    input  logic [31:0]      i_fu_out,
    input  logic [4:0]       i_fu_exc,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic [15:0]      o_rsp_data,
    output logic [4:0]       o_rsp_exc,
    output logic             o_busy
);

    localparam logic [3:0] OP_SGN  = 4'b0101;
    localparam logic [4:0] EXC_NV  = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [3:0]         r_op;
    logic [1:0]         r_sel;
    logic [15:0]        r_a;
    logic [15:0]        r_b;
    logic [TAG_W-1:0]   r_tag;
    logic               r_id;
    logic [3:0]         r_cnt;
    logic [15:0]        r_data;
    logic [4:0]         r_exc;
    logic               r_last;
    logic               r_busy;

    logic               w_grant;
    logic               w_any;
    logic               w_accept;
    logic               w_op_legal;
    logic [3:0]         w_op;
    logic [1:0]         w_sel;
    logic [15:0]        w_a;
    logic [15:0]        w_b;
    logic [TAG_W-1:0]   w_tag;
    logic [3:0]         w_lat;
    logic               w_unused_fu_hi;

    // Upper half of the unit result bus carries nothing for 16-bit ops.
    assign w_unused_fu_hi = ^i_fu_out[31:16];

    // Round-robin grant: a lone requester wins; on contention, the one not served last.
    always_comb begin
        w_grant = 1'b0;
        w_any   = i_req0_valid | i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
            w_grant = ~r_last;
        end else if (i_req1_valid) begin
            w_grant = 1'b1;
        end
    end

    // Winning request fields and the latency it needs.
    assign w_op  = w_grant ? i_req1_op  : i_req0_op;
    assign w_sel = w_grant ? i_req1_sel : i_req0_sel;
    assign w_a   = w_grant ? i_req1_a   : i_req0_a;
    assign w_b   = w_grant ? i_req1_b   : i_req0_b;
    assign w_tag = w_grant ? i_req1_tag : i_req0_tag;
    assign w_lat = (w_op == OP_SGN) ? 4'(LAT_SGN) : 4'(LAT_ARITH);

`ifdef DLF_SEQ_OPCHECK_EN
    assign w_op_legal = (w_op >= 4'd1) && (w_op <= 4'd5);
`else
    assign w_op_legal = 1'b1;
`endif

    // Accept only in IDLE, and never while reset is held.
    assign w_accept     = (r_state == S_IDLE) && w_any && rst_n;
    assign o_req0_ready = w_accept && !w_grant;
    assign o_req1_ready = w_accept && w_grant;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and unit-side outputs; operands reach the units only in EXEC.
    always_comb begin
        w_state_next = r_state;
        o_fu_ena     = 4'd0;
        o_fu_sel     = 2'd0;
        o_fu_in1     = 16'd0;
        o_fu_in2     = 16'd0;
        o_rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_op_legal ? S_EXEC : S_RESP;
                end
            end
            S_EXEC: begin
                o_fu_ena = r_op;
                o_fu_sel = r_sel;
                o_fu_in1 = r_a;
                o_fu_in2 = r_b;
                if (r_cnt == 4'd0) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operation latch, latency countdown, result capture and last-served pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= 4'd0;
            r_sel  <= 2'd0;
            r_a    <= 16'd0;
            r_b    <= 16'd0;
            r_tag  <= '0;
            r_id   <= 1'b0;
            r_cnt  <= 4'd0;
            r_data <= 16'd0;
            r_exc  <= 5'd0;
            r_last <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_op;
                        r_sel <= w_sel;
                        r_a   <= w_a;
                        r_b   <= w_b;
                        r_tag <= w_tag;
                        r_id  <= w_grant;
                        r_cnt <= w_lat;
                        if (!w_op_legal) begin
                            r_data <= 16'd0;
                            r_exc  <= EXC_NV;
                        end
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd0) begin
                        r_data <= i_fu_out[15:0];
                        r_exc  <= i_fu_exc;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_last <= r_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rsp_id   = r_id;
    assign o_rsp_tag  = r_tag;
    assign o_rsp_data = r_data;
    assign o_rsp_exc  = r_exc;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_dlfloat16_fpu_sequencer.sv
// Testbench for dlfloat16_fpu_sequencer: table-driven single operations plus
// hand-written arbitration, backpressure, reset and opcode-check sequences.
module tb_dlfloat16_fpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [1:0]  req0_sel, req1_sel;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_tag, req1_tag;
    logic [3:0]  fu_ena;
    logic [1:0]  fu_sel;
    logic [15:0] fu_in1, fu_in2;
    logic [31:0] fu_out;
    logic [4:0]  fu_exc;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [3:0]  rsp_tag;
    logic [15:0] rsp_data;
    logic [4:0]  rsp_exc;

    localparam logic [31:0] JUNK = 32'hFFFF_DEAD;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int cyc       = 0;

    dlfloat16_fpu_sequencer #(.LAT_SGN(1), .LAT_ARITH(3), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_op(req0_op),
        .i_req0_sel(req0_sel), .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_tag(req0_tag),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_op(req1_op),
        .i_req1_sel(req1_sel), .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_tag(req1_tag),
        .o_fu_ena(fu_ena), .o_fu_sel(fu_sel), .o_fu_in1(fu_in1), .o_fu_in2(fu_in2),
        .i_fu_out(fu_out), .i_fu_exc(fu_exc),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
        .o_rsp_tag(rsp_tag), .o_rsp_data(rsp_data), .o_rsp_exc(rsp_exc), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        id;
        logic [3:0]  op;
        logic [1:0]  sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
        logic [4:0]  exc;
        int          lat;
        logic [15:0] exp_data;
        logic [4:0]  exp_exc;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic drive_req(input logic id, input logic v, input logic [3:0] op,
                             input logic [1:0] sel, input logic [15:0] a,
                             input logic [15:0] b, input logic [3:0] tag);
        if (id == 1'b0) begin
            req0_valid = v; req0_op = op; req0_sel = sel; req0_a = a; req0_b = b; req0_tag = tag;
        end else begin
            req1_valid = v; req1_op = op; req1_sel = sel; req1_a = a; req1_b = b; req1_tag = tag;
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_fu"}, {26'd0, fu_ena, fu_sel, fu_in1, fu_in2}, 64'd0);
        chk({name, "_rsp"}, {34'd0, req0_ready, req1_ready, rsp_valid, rsp_id,
                             rsp_tag, rsp_data, rsp_exc, busy}, 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for the given requester's ready; returns at the accept cycle, sampled.
    task automatic wait_ready(input logic id, output logic got);
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            #1;
            if ((id == 1'b0) ? req0_ready : req1_ready) got = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output logic got);
        got = 1'b0;
        for (int w = 0; w < 30 && !got; w++) begin
            #1;
            if (rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
    endtask

    // One operation from a single requester; the FU result is presented only
    // in the final EXEC cycle so early or late capture picks up junk.
    task automatic do_op(input vec_t v, input int n);
        logic got;
        @(negedge clk);
        fu_out = JUNK; fu_exc = 5'h1F;
        drive_req(v.id, 1'b1, v.op, v.sel, v.a, v.b, v.tag);
        wait_ready(v.id, got);
        chk($sformatf("v%0d_accept", n), {63'd0, got}, 64'd1);
        if (!got) begin
            drive_req(v.id, 1'b0, 4'd0, 2'd0, 16'd0, 16'd0, 4'd0);
            return;
        end
        chk($sformatf("v%0d_other_ready", n), {63'd0, (v.id ? req0_ready : req1_ready)}, 64'd0);
        @(negedge clk);
        drive_req(v.id, 1'b0, 4'd0, 2'd0, 16'd0, 16'd0, 4'd0);
        for (int k = 0; k <= v.lat; k++) begin
            fu_out = (k == v.lat) ? v.res : JUNK;
            fu_exc = (k == v.lat) ? v.exc : 5'h1F;
            #1;
            chk($sformatf("v%0d_exec%0d_fu", n, k), {26'd0, fu_ena, fu_sel, fu_in1, fu_in2},
                {26'd0, v.op, v.sel, v.a, v.b});
            chk($sformatf("v%0d_exec%0d_vb", n, k), {62'd0, rsp_valid, busy}, 64'd1);
            @(negedge clk);
        end
        fu_out = JUNK; fu_exc = 5'h1F;
        #1;
        chk($sformatf("v%0d_rsp_valid", n), {63'd0, rsp_valid}, 64'd1);
        chk($sformatf("v%0d_rsp", n), {38'd0, rsp_id, rsp_tag, rsp_data, rsp_exc},
            {38'd0, v.id, v.tag, v.exp_data, v.exp_exc});
        chk($sformatf("v%0d_rsp_fu_idle", n), {60'd0, fu_ena}, 64'd0);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_after", n), {62'd0, rsp_valid, busy}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic got;
        int   last_rsp;
        int   seen;
        vec_t v;

        //        id   op       sel    a         b         tag    res            exc       L  exp_data  exp_exc
        vecs[0] = '{1'b0, 4'b0101, 2'b00, 16'h3C00, 16'h0000, 4'h3, 32'hA5A5_BC00, 5'b00000, 1, 16'hBC00, 5'b00000};
        vecs[1] = '{1'b1, 4'b0101, 2'b11, 16'h8000, 16'hC200, 4'h9, 32'h0000_4200, 5'b00000, 1, 16'h4200, 5'b00000};
        vecs[2] = '{1'b0, 4'b0001, 2'b01, 16'h3C00, 16'h4000, 4'h5, 32'h1234_4200, 5'b00001, 3, 16'h4200, 5'b00001};
        vecs[3] = '{1'b1, 4'b0011, 2'b10, 16'h7BFF, 16'h7BFF, 4'hF, 32'hFFFF_7C00, 5'b00101, 3, 16'h7C00, 5'b00101};
        vecs[4] = '{1'b0, 4'b0100, 2'b00, 16'h0001, 16'h0000, 4'h0, 32'h0000_0000, 5'b00010, 3, 16'h0000, 5'b00010};

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        fu_out = JUNK; fu_exc = 5'h1F;
        drive_req(1'b0, 1'b1, 4'b0001, 2'd1, 16'h1111, 16'h2222, 4'h1);
        drive_req(1'b1, 1'b1, 4'b0101, 2'd2, 16'h3333, 16'h4444, 4'h2);

        // Reset state, with both requesters asking.
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);

        // Arbitration: both valid from reset release, continuously.
        drive_req(1'b0, 1'b1, 4'b0001, 2'd0, 16'h1000, 16'h0000, 4'hA);
        drive_req(1'b1, 1'b1, 4'b0001, 2'd0, 16'h2000, 16'h0000, 4'hB);
        fu_out = 32'h0000_1111; fu_exc = 5'd0;
        rst_n = 1'b1;
        last_rsp = 0;
        for (int n = 0; n < 4; n++) begin
            got = 1'b0;
            for (int w = 0; w < 20 && !got; w++) begin
                #1;
                if (req0_ready | req1_ready) got = 1'b1;
                else @(negedge clk);
            end
            chk($sformatf("arb%0d_accept", n), {63'd0, got}, 64'd1);
            chk($sformatf("arb%0d_grant", n), {62'd0, req1_ready, req0_ready},
                (n % 2 == 1) ? 64'd2 : 64'd1);
            if (n > 0) chk($sformatf("arb%0d_gap", n), 64'(cyc), 64'(last_rsp + 1));
            @(negedge clk);
            wait_rsp(got);
            chk($sformatf("arb%0d_rsp", n), {63'd0, got}, 64'd1);
            chk($sformatf("arb%0d_id_tag", n), {59'd0, rsp_id, rsp_tag},
                (n % 2 == 1) ? {59'd0, 1'b1, 4'hB} : {59'd0, 1'b0, 4'hA});
            last_rsp = cyc;
            if (n == 3) begin
                drive_req(1'b0, 1'b0, 4'd0, 2'd0, 16'd0, 16'd0, 4'd0);
                drive_req(1'b1, 1'b0, 4'd0, 2'd0, 16'd0, 16'd0, 4'd0);
            end
            @(negedge clk);
        end

        // Table-driven single operations.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i], i);
        end

        // Backpressure: response held for 5 extra cycles while req1 waits.
        @(negedge clk);
        rsp_ready = 1'b0;
        fu_out = 32'h0000_2468; fu_exc = 5'b01000;
        drive_req(1'b0, 1'b1, 4'b0001, 2'd0, 16'h1234, 16'h5678, 4'h7);
        wait_ready(1'b0, got);
        chk("bp_accept", {63'd0, got}, 64'd1);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 4'd0, 2'd0, 16'd0, 16'd0, 4'd0);
        drive_req(1'b1, 1'b1, 4'b0001, 2'd0, 16'h0F0F, 16'h0000, 4'h6);
        wait_rsp(got);
        chk("bp_rsp", {63'd0, got}, 64'd1);
        fu_out = JUNK; fu_exc = 5'h1F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp%0d_valid_busy", i), {62'd0, rsp_valid, busy}, 64'd3);
            chk($sformatf("bp%0d_hold", i), {38'd0, rsp_id, rsp_tag, rsp_data, rsp_exc},
                {38'd0, 1'b0, 4'h7, 16'h2468, 5'b01000});
            chk($sformatf("bp%0d_ready", i), {62'd0, req0_ready, req1_ready}, 64'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        drive_req(1'b1, 1'b0, 4'd0, 2'd0, 16'd0, 16'd0, 4'd0);
        #1;
        chk("bp_release_valid", {63'd0, rsp_valid}, 64'd1);
        @(negedge clk);
        #1;
        chk("bp_drop_valid", {63'd0, rsp_valid}, 64'd0);

        // Reset during EXEC of an arithmetic op; last served was req0 before it.
        @(negedge clk);
        fu_out = 32'h0000_9999; fu_exc = 5'd0;
        drive_req(1'b0, 1'b1, 4'b0010, 2'd0, 16'hAAAA, 16'h5555, 4'hC);
        wait_ready(1'b0, got);
        chk("mr_accept", {63'd0, got}, 64'd1);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 4'd0, 2'd0, 16'd0, 16'd0, 4'd0);
        @(negedge clk);
        #1;
        chk("mr_in_exec", {60'd0, fu_ena}, 64'd2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mr_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (rsp_valid || busy) seen++;
            @(negedge clk);
        end
        chk("mr_no_rsp", 64'(seen), 64'd0);
        drive_req(1'b0, 1'b1, 4'b0001, 2'd0, 16'h0101, 16'h0000, 4'h1);
        drive_req(1'b1, 1'b1, 4'b0001, 2'd0, 16'h0202, 16'h0000, 4'h2);
        #1;
        chk("mr_prio", {62'd0, req1_ready, req0_ready}, 64'd1);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 4'd0, 2'd0, 16'd0, 16'd0, 4'd0);
        drive_req(1'b1, 1'b0, 4'd0, 2'd0, 16'd0, 16'd0, 4'd0);
        wait_rsp(got);
        chk("mr_prio_rsp", {59'd0, got, rsp_tag}, {59'd0, 1'b1, 4'h1});
        @(negedge clk);

        // Illegal opcode 1010.
`ifdef DLF_SEQ_OPCHECK_EN
        @(negedge clk);
        fu_out = JUNK; fu_exc = 5'h1F;
        drive_req(1'b0, 1'b1, 4'b1010, 2'd0, 16'h1234, 16'h4321, 4'h8);
        wait_ready(1'b0, got);
        chk("oc_accept", {63'd0, got}, 64'd1);
        chk("oc_fu_t", {60'd0, fu_ena}, 64'd0);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 4'd0, 2'd0, 16'd0, 16'd0, 4'd0);
        #1;
        chk("oc_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("oc_rsp", {38'd0, rsp_id, rsp_tag, rsp_data, rsp_exc},
            {38'd0, 1'b0, 4'h8, 16'h0000, 5'b10000});
        chk("oc_fu_t1", {60'd0, fu_ena}, 64'd0);
        @(negedge clk);
        #1;
        chk("oc_after", {62'd0, rsp_valid, busy}, 64'd0);
`else
        v = '{1'b0, 4'b1010, 2'b01, 16'h1234, 16'h4321, 4'h8, 32'h0000_6543, 5'b00100, 3, 16'h6543, 5'b00100};
        do_op(v, 9);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
